// File: rtl/block_check_arbiter.sv
// Round-robin arbiter that lends one BlockChecker to two byte-stream requesters, one message at a time.
// Optional stall watchdog: define BLOCK_CHECK_ARBITER_WATCHDOG_EN.
module block_check_arbiter #(
  parameter logic [7:0] IDLE_CHAR = 8'h20,
  parameter int         SETTLE    = 2,
  parameter int         TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       chk_reset,
  output logic [7:0] chk_in,
  input  logic       chk_result,
  output logic [1:0] done,
  output logic [1:0] result,
  output logic [1:0] err,
  output logic       busy,
  output logic       owner
);

  // One counter serves both the settle delay and the stall watchdog.
  localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_XFER, S_SETTLE, S_REPORT} state_t;

  state_t            state, state_n;
  logic [1:0]        vld, lst;
  logic [1:0][7:0]   dat;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              last_grant, last_grant_n, owner_n, chk_reset_n, busy_n;
  logic [7:0]        chk_in_n;
  logic [1:0]        done_n, result_n;
  logic              grant, hs;

  assign vld = {req1_valid, req0_valid};
  assign lst = {req1_last, req0_last};
  assign dat = {req1_data, req0_data};

  assign req0_ready = (state == S_XFER) && !owner;
  assign req1_ready = (state == S_XFER) && owner;

`ifdef BLOCK_CHECK_ARBITER_WATCHDOG_EN
  logic [1:0] err_q, err_n;
  assign err = err_q;
`else
  assign err = 2'b00;
`endif

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    last_grant_n = last_grant;
    owner_n      = owner;
    chk_reset_n  = chk_reset;
    chk_in_n     = IDLE_CHAR;
    done_n       = 2'b00;
    result_n     = result;
`ifdef BLOCK_CHECK_ARBITER_WATCHDOG_EN
    err_n        = err_q;
`endif
    grant        = 1'b0;
    hs           = (state == S_XFER) && vld[owner];
    case (state)
      S_IDLE: begin
        if (|vld) begin
          grant        = (vld == 2'b11) ? ~last_grant : vld[1];
          owner_n      = grant;
          last_grant_n = grant;
          chk_reset_n  = 1'b1;
          state_n      = S_CLR;
        end
      end
      S_CLR: begin
        chk_reset_n = 1'b0;
        cnt_n       = '0;
        state_n     = S_XFER;
      end
      S_XFER: begin
        if (hs) begin
          chk_in_n = dat[owner];
          cnt_n    = '0;
          if (lst[owner]) state_n = S_SETTLE;
        end
`ifdef BLOCK_CHECK_ARBITER_WATCHDOG_EN
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          result_n[owner] = 1'b0;
          err_n[owner]    = 1'b1;
          done_n[owner]   = 1'b1;
          state_n         = S_REPORT;
        end
        else cnt_n = cnt + 1'b1;
`endif
      end
      S_SETTLE: begin
        // Sample only after the trailing delimiters have been consumed.
        if (cnt == CNT_W'(SETTLE)) begin
          result_n[owner] = chk_result;
          done_n[owner]   = 1'b1;
`ifdef BLOCK_CHECK_ARBITER_WATCHDOG_EN
          err_n[owner]    = 1'b0;
`endif
          state_n         = S_REPORT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_REPORT: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b1;
      chk_reset  <= 1'b0;
      chk_in     <= IDLE_CHAR;
      done       <= 2'b00;
      result     <= 2'b00;
      busy       <= 1'b0;
`ifdef BLOCK_CHECK_ARBITER_WATCHDOG_EN
      err_q      <= 2'b00;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last_grant <= last_grant_n;
      owner      <= owner_n;
      chk_reset  <= chk_reset_n;
      chk_in     <= chk_in_n;
      done       <= done_n;
      result     <= result_n;
      busy       <= busy_n;
`ifdef BLOCK_CHECK_ARBITER_WATCHDOG_EN
      err_q      <= err_n;
`endif
    end
  end

endmodule
